// File: rtl/spmv_row_scheduler.sv
// Row-at-a-time sequencer for the SpMV datapath: issues K-lane chunks, tracks them, sums the row.
// Define SPMV_SAT_EN for saturating accumulation with a sticky per-row overflow flag (default: wrap, res_ovf=0).
module spmv_row_scheduler #(
  parameter int K        = 4,
  parameter int PIPE_LAT = 4,
  parameter int PS_W     = 20,
  parameter int ACC_W    = 24,
  parameter int LEN_W    = 8,
  parameter int ROW_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ROW_W-1:0] cmd_row,
  input  logic [LEN_W-1:0] cmd_nnz,
  input  logic             chunk_valid,
  output logic             chunk_ready,
  output logic             dp_issue,
  output logic [K-1:0]     dp_mask,
  output logic             dp_last,
  input  logic [PS_W-1:0]  ps_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ROW_W-1:0] res_row,
  output logic [ACC_W-1:0] res_sum,
  output logic             res_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

  state_t                    r_state, w_next;
  logic [LEN_W-1:0]          r_rem, w_take;
  logic signed [ACC_W-1:0]   r_acc, r_res_sum, w_ps_ext, w_sum;
  logic [ROW_W-1:0]          r_res_row;
  logic [PIPE_LAT-1:0]       r_dl_issue, r_dl_last;
  logic [K-1:0]              w_mask;
  logic                      w_accept, w_tap_issue, w_tap_last;

  assign w_accept    = (r_state == S_IDLE) && cmd_valid;
  assign w_tap_issue = r_dl_issue[PIPE_LAT-1];
  assign w_tap_last  = r_dl_last[PIPE_LAT-1];
  assign w_ps_ext    = {{(ACC_W-PS_W){ps_data[PS_W-1]}}, ps_data};
  assign w_take      = (r_rem >= LEN_W'(K)) ? LEN_W'(K) : r_rem;
  assign res_row     = r_res_row;
  assign res_sum     = r_res_sum;

`ifdef SPMV_SAT_EN
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    // Top two bits disagree only when the true sum left the ACC_W range; clamp toward its sign.
    if (s[ACC_W] != s[ACC_W-1]) sat_add = {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
    else                        sat_add = {1'b0, s[ACC_W-1:0]};
  endfunction

  logic [ACC_W:0] w_add;
  logic           r_ovf, r_res_ovf;

  assign w_add   = sat_add(r_acc, w_ps_ext);
  assign w_sum   = w_add[ACC_W-1:0];
  assign res_ovf = r_res_ovf;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ovf     <= 1'b0;
      r_res_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf     <= 1'b0;
      r_res_ovf <= 1'b0;
    end else if (w_tap_issue) begin
      if (w_tap_last) begin
        r_res_ovf <= r_ovf | w_add[ACC_W];
        r_ovf     <= 1'b0;
      end else begin
        r_ovf     <= r_ovf | w_add[ACC_W];
      end
    end
  end
`else
  function automatic logic signed [ACC_W-1:0] wrap_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] b);
    wrap_add = a + b;
  endfunction

  assign w_sum   = wrap_add(r_acc, w_ps_ext);
  assign res_ovf = 1'b0;
`endif

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < K; i++) w_mask[i] = (LEN_W'(i) < r_rem);
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    cmd_ready   = 1'b0;
    chunk_ready = 1'b0;
    dp_issue    = 1'b0;
    dp_mask     = '0;
    dp_last     = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) w_next = (cmd_nnz == '0) ? S_OUT : S_ISSUE;
      end
      S_ISSUE: begin
        chunk_ready = 1'b1;
        if (chunk_valid) begin
          dp_issue = 1'b1;
          dp_mask  = w_mask;
          dp_last  = (r_rem <= LEN_W'(K));
          if (dp_last) w_next = S_DRAIN;
        end
      end
      S_DRAIN: if (w_tap_issue && w_tap_last) w_next = S_OUT;
      S_OUT: begin
        res_valid = 1'b1;
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Delay line, remaining count and accumulator
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rem      <= '0;
      r_acc      <= '0;
      r_dl_issue <= '0;
      r_dl_last  <= '0;
      r_res_row  <= '0;
      r_res_sum  <= '0;
    end else begin
      r_dl_issue[0] <= dp_issue;
      r_dl_last[0]  <= dp_last;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_dl_issue[i] <= r_dl_issue[i-1];
        r_dl_last[i]  <= r_dl_last[i-1];
      end
      if (w_accept) begin
        r_res_row <= cmd_row;
        r_rem     <= cmd_nnz;
        r_acc     <= '0;
        if (cmd_nnz == '0) r_res_sum <= '0;
      end
      if (dp_issue) r_rem <= r_rem - w_take;
      if (w_tap_issue) begin
        if (w_tap_last) begin
          r_res_sum <= w_sum;
          r_acc     <= '0;
        end else begin
          r_acc     <= w_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_spmv_row_scheduler.sv
// Randomized self-checking bench for spmv_row_scheduler against a per-row arithmetic model.
module tb_spmv_row_scheduler;
  localparam int K = 4, PIPE_LAT = 4, PS_W = 20, ACC_W = 24, LEN_W = 8, ROW_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [ROW_W-1:0] cmd_row;
  logic [LEN_W-1:0] cmd_nnz;
  logic             chunk_valid, chunk_ready;
  logic             dp_issue, dp_last;
  logic [K-1:0]     dp_mask;
  logic [PS_W-1:0]  ps_data;
  logic             res_valid, res_ready;
  logic [ROW_W-1:0] res_row;
  logic [ACC_W-1:0] res_sum;
  logic             res_ovf;
  logic             busy;

  int n_cmp = 0, n_fail = 0;
  int ps_vals [0:255];
  int pipe    [0:PIPE_LAT-1];

  spmv_row_scheduler #(.K(K), .PIPE_LAT(PIPE_LAT), .PS_W(PS_W), .ACC_W(ACC_W),
                       .LEN_W(LEN_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_row(cmd_row), .cmd_nnz(cmd_nnz), .chunk_valid(chunk_valid),
    .chunk_ready(chunk_ready), .dp_issue(dp_issue), .dp_mask(dp_mask),
    .dp_last(dp_last), .ps_data(ps_data), .res_valid(res_valid),
    .res_ready(res_ready), .res_row(res_row), .res_sum(res_sum),
    .res_ovf(res_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Row result straight from the arithmetic rules: sum of one partial sum per chunk.
  task automatic model(input int nnz, output logic [ACC_W-1:0] sum, output logic ovf);
    longint s, mx, mn;
    s  = 0;
    mx = (longint'(1) << (ACC_W-1)) - 1;
    mn = -(longint'(1) << (ACC_W-1));
    ovf = 1'b0;
    for (int c = 0; c < (nnz + K - 1) / K; c++) begin
      s += ps_vals[c];
`ifdef SPMV_SAT_EN
      if (s > mx) begin s = mx; ovf = 1'b1; end
      else if (s < mn) begin s = mn; ovf = 1'b1; end
`endif
    end
    sum = s[ACC_W-1:0];
  endtask

  task automatic push(input int v);
    for (int i = PIPE_LAT-1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = v;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".cmd_ready"},   cmd_ready,   1);
    chk({tag, ".chunk_ready"}, chunk_ready, 0);
    chk({tag, ".dp_issue"},    dp_issue,    0);
    chk({tag, ".dp_mask"},     dp_mask,     0);
    chk({tag, ".dp_last"},     dp_last,     0);
    chk({tag, ".res_valid"},   res_valid,   0);
    chk({tag, ".res_row"},     res_row,     0);
    chk({tag, ".res_sum"},     res_sum,     0);
    chk({tag, ".res_ovf"},     res_ovf,     0);
    chk({tag, ".busy"},        busy,        0);
  endtask

  task automatic run_row(input int row, input int nnz, input int gapmax,
                         input int rdy_delay, input bit hold_cmd, input string tag);
    int chunks, issued, t_last, t_res, lanes, tap, exp_t;
    bit done;
    logic [ACC_W-1:0] exp_sum;
    logic exp_ovf;
    model(nnz, exp_sum, exp_ovf);
    chunks = (nnz + K - 1) / K;
    issued = 0; t_last = 0; t_res = -1; done = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++) pipe[i] = -1;
    cmd_valid = 1'b1; cmd_row = ROW_W'(row); cmd_nnz = LEN_W'(nnz);
    chunk_valid = 1'b0; res_ready = 1'b0; ps_data = PS_W'($urandom);
    @(negedge clk);
    chk({tag, ".accept_ready"}, cmd_ready, 1);
    chk({tag, ".accept_busy"},  busy,      0);
    push(-1);
    @(posedge clk); #1;
    cmd_valid = hold_cmd; cmd_row = ROW_W'($urandom); cmd_nnz = LEN_W'($urandom);
    for (int cyc = 1; cyc < 600 && !done; cyc++) begin
      chunk_valid = (issued < chunks) && ($urandom_range(0, gapmax) == 0);
      tap = pipe[PIPE_LAT-1];
      ps_data = (tap >= 0) ? PS_W'(ps_vals[tap]) : PS_W'($urandom);
      res_ready = (rdy_delay == 0) || (t_res >= 0 && cyc - t_res >= rdy_delay);
      @(negedge clk);
      chk({tag, ".cmd_ready_busy"}, cmd_ready, 0);
      chk({tag, ".busy"}, busy, 1);
      chk({tag, ".issue"}, dp_issue, chunk_valid);
      chk({tag, ".chunk_ready"}, chunk_ready, issued < chunks);
      if (dp_issue) begin
        lanes = (nnz - issued * K >= K) ? K : nnz - issued * K;
        chk({tag, ".mask"}, dp_mask, (1 << lanes) - 1);
        chk({tag, ".last"}, dp_last, issued == chunks - 1);
        if (issued == chunks - 1) t_last = cyc;
        push(issued);
        issued++;
      end else begin
        chk({tag, ".idle_mask"}, {dp_mask, dp_last}, 0);
        push(-1);
      end
      if (res_valid) begin
        if (t_res < 0) begin
          t_res = cyc;
          exp_t = (nnz == 0) ? 1 : t_last + PIPE_LAT + 1;
          chk({tag, ".res_time"}, cyc, exp_t);
        end
        chk({tag, ".res_row"}, res_row, row);
        chk({tag, ".res_sum"}, res_sum, exp_sum);
        chk({tag, ".res_ovf"}, res_ovf, exp_ovf);
        if (res_ready) done = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk({tag, ".handshake"}, done, 1);
    chk({tag, ".chunks"}, issued, chunks);
    chk({tag, ".ready_after"}, cmd_ready, 1);
    chk({tag, ".valid_after"}, res_valid, 0);
    cmd_valid = 1'b0; res_ready = 1'b0; chunk_valid = 1'b0;
  endtask

  initial begin
    int nnz;
    rst = 1'b0; cmd_valid = 1'b0; cmd_row = '0; cmd_nnz = '0;
    chunk_valid = 1'b0; res_ready = 1'b0; ps_data = '0;
    repeat (2) @(posedge clk); #1;
    check_reset("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    run_row(7, 0, 0, 0, 1'b0, "t1_empty");

    ps_vals[0] = 100;
    run_row(3, 4, 0, 0, 1'b0, "t2_single");

    ps_vals[0] = 5; ps_vals[1] = -7; ps_vals[2] = 3;
    run_row(12, 10, 0, 0, 1'b0, "t3_three");

    for (int i = 0; i < 3; i++) ps_vals[i] = int'($urandom_range(0, 2000)) - 1000;
    run_row(513, 9, 2, 3, 1'b1, "t4_gaps");

    // Reset during DRAIN, one cycle before the last chunk reaches the tap
    cmd_valid = 1'b1; cmd_row = 10'd55; cmd_nnz = 8'd4;
    chk("t5.accept_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; chunk_valid = 1'b1;
    @(negedge clk);
    chk("t5.issue", dp_issue, 1);
    chk("t5.last", dp_last, 1);
    @(posedge clk); #1;
    chunk_valid = 1'b0;
    repeat (PIPE_LAT - 2) @(posedge clk); #1;
    rst = 1'b0; ps_data = PS_W'($urandom);
    @(posedge clk); #1;
    ps_data = PS_W'($urandom);
    check_reset("t5_rst");
    rst = 1'b1;
    for (int i = 0; i < PIPE_LAT + 2; i++) begin
      ps_data = PS_W'($urandom);
      @(negedge clk);
      chk("t5.no_result", {res_valid, busy}, 0);
      @(posedge clk); #1;
    end
    ps_vals[0] = 42;
    run_row(9, 4, 0, 0, 1'b0, "t5_after");

    for (int i = 0; i < 17; i++) ps_vals[i] = 524287;
    run_row(1023, 68, 0, 0, 1'b0, "t6_big");

    for (int r = 0; r < 12; r++) begin
      nnz = (r == 0) ? 255 : int'($urandom_range(0, 40));
      for (int i = 0; i < 64; i++)
        ps_vals[i] = int'($urandom_range(0, (1 << PS_W) - 1)) - (1 << (PS_W - 1));
      run_row(int'($urandom_range(0, 1023)), nnz, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
